// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the transmitter/receiver
// FSM state encoding. Imported by uart_tx, its FIFO, its interface and uart_rx.
package uart_pkg;

  // Payload bits per frame; data is sent LSB first.
  localparam int DATA_BITS = 8;

  // Line levels for the framing bits; the line idles at STOP_BIT.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Frame sequencer states, shared by transmitter and receiver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// Byte-stream side of the UART transmitter: valid/ready push port, enable,
// serial line and status. FIFO_DEPTH must match the transmitter instance so
// that fifo_count has the same width on both sides.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);

  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_enable;
  logic                 tx_out;
  logic                 tx_busy;
  logic [COUNT_W-1:0]   fifo_count;

  // Producer of bytes and owner of the enable.
  modport master (
    output tx_data,
    output tx_valid,
    output tx_enable,
    input  tx_ready,
    input  tx_out,
    input  tx_busy,
    input  fifo_count
  );

  // The transmitter itself.
  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_enable,
    output tx_ready,
    output tx_out,
    output tx_busy,
    output fifo_count
  );

endinterface : uart_tx_if

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO. Show-ahead read: rd_data always presents the
// head entry, and pop retires it on the clock edge. count, full and empty are
// all registered so nothing downstream sees a combinational path from push.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       rxclk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       pop,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count_next;
  logic                 do_push;
  logic                 do_pop;

  // Guard both ports so a stray request can never over- or under-run.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Occupancy after this edge: push and pop together cancel out.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding its old value (which would infer a latch).
    count_next = count;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally at DEPTH (power of two); flags track count_next.
  always_ff @(posedge rxclk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == COUNT_FULL);
      empty <= (count_next == '0);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge rxclk) begin
    // NOTE: the data array is deliberately not reset; pointers and count define which entries are valid, and a reset-free array maps onto plain RAM.
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule : uart_tx_fifo

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/stop frame sequencer.
// Each line bit lasts OVERSAMPLE rxclk cycles; STOP lasts OVERSAMPLE*STOP_BITS.
// tx_out comes straight from a flop, so the line never glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,  // rxclk cycles per bit, power of two, 4..16
  parameter int FIFO_DEPTH = 4,   // FIFO entries, power of two, 2..16
  parameter int STOP_BITS  = 1    // 1 or 2
) (
  input  logic       rxclk,
  input  logic       reset,
  uart_tx_if.slave   bus
);

  localparam int COUNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int STOP_CYCLES = OVERSAMPLE * STOP_BITS;
  localparam int OS_W        = $clog2(STOP_CYCLES);

  // Last cycle of a start/data bit, and of the whole stop period.
  localparam logic [OS_W-1:0] BIT_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] STOP_LAST = OS_W'(STOP_CYCLES - 1);
  localparam logic [2:0]      IDX_LAST  = 3'(DATA_BITS - 1);

  // FIFO connections.
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [COUNT_W-1:0]   fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;

  // Sequencer state and datapath, current and next.
  uart_state_e          state,     state_next;
  logic [OS_W-1:0]      os_cnt,    os_next;
  logic [2:0]           bit_cnt,   bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 tx_q,      tx_next;
  logic                 busy_q;
  logic                 can_start;
  logic                 start_frame;

  // A byte is taken only while the registered ready is high.
  assign fifo_push = bus.tx_valid && !fifo_full;

  // A new frame may begin only with data waiting and the enable set.
  assign can_start = !fifo_empty && bus.tx_enable;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .rxclk   (rxclk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (bus.tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state and datapath decode for the frame sequencer.
  always_comb begin
    state_next  = state;
    os_next     = os_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    tx_next     = tx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    unique case (state)
      IDLE: begin
        tx_next = STOP_BIT;
        if (can_start) start_frame = 1'b1;
      end

      START: begin
        if (os_cnt == BIT_LAST) begin
          state_next = DATA;
          os_next    = '0;
          tx_next    = shift_reg[0];
        end else begin
          os_next = os_cnt + 1'b1;
        end
      end

      DATA: begin
        if (os_cnt == BIT_LAST) begin
          os_next = '0;
          if (bit_cnt == IDX_LAST) begin
            state_next = STOP;
            tx_next    = STOP_BIT;
          end else begin
            // Shift the next payload bit into position 0 and drive it.
            bit_next   = bit_cnt + 1'b1;
            shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
            tx_next    = shift_reg[1];
          end
        end else begin
          os_next = os_cnt + 1'b1;
        end
      end

      STOP: begin
        if (os_cnt == STOP_LAST) begin
          if (can_start) begin
            // Chain straight into the next frame with no idle gap.
            start_frame = 1'b1;
          end else begin
            state_next = IDLE;
            os_next    = '0;
            tx_next    = STOP_BIT;
          end
        end else begin
          os_next = os_cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = STOP_BIT;
      end
    endcase

    // Load the FIFO head and drive the start bit from this edge.
    if (start_frame) begin
      fifo_pop   = 1'b1;
      shift_next = fifo_rd_data;
      tx_next    = START_BIT;
      os_next    = '0;
      bit_next   = '0;
      state_next = START;
    end
  end

  // Sequencer registers; reset aborts any frame and parks the line high.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      os_cnt    <= os_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      tx_q      <= tx_next;
      busy_q    <= (state_next != IDLE);
    end
  end

  assign bus.tx_out     = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_ready   = !fifo_full;
  assign bus.fifo_count = fifo_count;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default build (16x oversample, 1 stop bit) watched by a
// behavioural receiver, plus an 8x oversample, 2-stop-bit build for frame timing.
module tb_uart_tx;

  localparam int OS = 16;

  logic rxclk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Receiver model output.
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         frame_err = 0;

  uart_tx_if #(.FIFO_DEPTH(4)) b1 ();
  uart_tx_if #(.FIFO_DEPTH(4)) b2 ();

  uart_tx #(.OVERSAMPLE(16), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .rxclk (rxclk),
    .reset (reset),
    .bus   (b1)
  );

  uart_tx #(.OVERSAMPLE(8), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .rxclk (rxclk),
    .reset (reset),
    .bus   (b2)
  );

  initial begin
    rxclk = 1'b0;
    forever #5 rxclk = ~rxclk;
  end

  always @(posedge rxclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge rxclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    b1.tx_data  = b;
    b1.tx_valid = 1'b1;
    step();
    b1.tx_valid = 1'b0;
  endtask

  task automatic push2(input logic [7:0] b);
    b2.tx_data  = b;
    b2.tx_valid = 1'b1;
    step();
    b2.tx_valid = 1'b0;
  endtask

  // Expected line level at cycle i of a frame carrying d (start = cycle 0).
  function automatic logic exp_line(input logic [7:0] d, input int os, input int i);
    int slot;
    slot = i / os;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return 1'b1;
  endfunction

  // Compare everything the receiver model decoded against the expected bytes.
  task automatic check_rx(input string tag, input logic [7:0] exp_q[$]);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < rx_q.size()) ? {1'b0, rx_q[i]} : 9'h100, {1'b0, exp_q[i]});
    end
  endtask

  // Behavioural receiver: sample mid-bit, log bytes, start cycles and framing errors.
  initial begin : rx_monitor
    logic [7:0] d;
    forever begin
      step();
      if (!reset && b1.tx_out === 1'b0) begin
        start_q.push_back(cyc);
        repeat (OS / 2 - 1) step();
        if (b1.tx_out !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (OS) step();
          d[i] = b1.tx_out;
        end
        repeat (OS) step();
        if (b1.tx_out !== 1'b1) frame_err++;
        rx_q.push_back(d);
      end
    end
  end

  initial begin : main
    logic [7:0] b;
    logic [7:0] exp_q[$];
    int         n;
    int         w;
    int         c0;
    int         c1;
    int         mcount;
    int         n_low;
    int         n_busy;

    reset        = 1'b1;
    b1.tx_data   = '0;
    b1.tx_valid  = 1'b0;
    b1.tx_enable = 1'b1;
    b2.tx_data   = '0;
    b2.tx_valid  = 1'b0;
    b2.tx_enable = 1'b1;
    repeat (3) step();

    // Reset state.
    check("rst_tx_out", b1.tx_out, 1);
    check("rst_busy", b1.tx_busy, 0);
    check("rst_ready", b1.tx_ready, 1);
    check("rst_count", b1.fifo_count, 0);
    reset = 1'b0;
    repeat (2) step();

    // Single 0x55 frame, cycle by cycle.
    push1(8'h55);
    check("lat_before", b1.tx_out, 1);
    step();
    for (int i = 0; i < 160; i++) begin
      check($sformatf("w55_line_c%0d", i), b1.tx_out, exp_line(8'h55, OS, i));
      check($sformatf("w55_busy_c%0d", i), b1.tx_busy, 1);
      step();
    end
    check("w55_busy_end", b1.tx_busy, 0);
    check("w55_line_end", b1.tx_out, 1);

    // "Hi" back-to-back through the receiver model.
    rx_q.delete();
    start_q.delete();
    frame_err = 0;
    push1(8'h48);
    push1(8'h69);
    n = 0;
    while (b1.tx_busy === 1'b1 && n < 2000) begin
      n++;
      step();
    end
    check("hi_busy_cycles", n, 320);
    exp_q = '{8'h48, 8'h69};
    check_rx("hi", exp_q);
    check("hi_frame_err", frame_err, 0);
    check("hi_period", (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1, 160);

    // Fill with the enable low, then drain; push and pop on the same edge.
    rx_q.delete();
    start_q.delete();
    exp_q.delete();
    b1.tx_enable = 1'b0;
    step();
    mcount = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      push1(b);
      if (mcount < 4) begin
        mcount++;
        exp_q.push_back(b);
      end
      check($sformatf("fill_count%0d", i), b1.fifo_count, mcount);
      check($sformatf("fill_ready%0d", i), b1.tx_ready, mcount < 4);
    end
    check("fill_busy", b1.tx_busy, 0);
    check("fill_line", b1.tx_out, 1);
    b1.tx_enable = 1'b1;
    step();
    mcount--;
    check("drain_count", b1.fifo_count, mcount);
    check("drain_ready", b1.tx_ready, 1);
    check("drain_line", b1.tx_out, 0);
    repeat (159) step();
    b = 8'($urandom_range(0, 255));
    push1(b);
    exp_q.push_back(b);
    check("pushpop_count", b1.fifo_count, mcount);
    check("pushpop_line", b1.tx_out, 0);
    w = 0;
    while ((rx_q.size() < exp_q.size() || b1.tx_busy === 1'b1) && w < 3000) begin
      step();
      w++;
    end
    check_rx("drain", exp_q);
    check("drain_period", (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1, 160);

    // Random bytes, random gaps, random enable pauses.
    rx_q.delete();
    exp_q.delete();
    frame_err = 0;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 3) == 0) begin
        b1.tx_enable = 1'b0;
        repeat ($urandom_range(1, 200)) step();
        b1.tx_enable = 1'b1;
      end
      w = 0;
      while (b1.tx_ready !== 1'b1 && w < 400) begin
        step();
        w++;
      end
      check($sformatf("rand_ready%0d", i), b1.tx_ready, 1);
      b = 8'($urandom_range(0, 255));
      push1(b);
      exp_q.push_back(b);
    end
    w = 0;
    while ((rx_q.size() < exp_q.size() || b1.tx_busy === 1'b1) && w < 5000) begin
      step();
      w++;
    end
    check_rx("rand", exp_q);
    check("rand_frame_err", frame_err, 0);

    // Enable dropped mid-frame: frame completes, queue retained.
    rx_q.delete();
    push1(8'hA3);
    c0 = cyc + 1;
    push1(8'h11);
    push1(8'h22);
    repeat (39) step();
    b1.tx_enable = 1'b0;
    w = 0;
    while (b1.tx_busy === 1'b1 && w < 1000) begin
      step();
      w++;
    end
    check("a3_frame_len", cyc - c0, 160);
    repeat (20) step();
    check("a3_busy", b1.tx_busy, 0);
    check("a3_line", b1.tx_out, 1);
    check("a3_count", b1.fifo_count, 2);
    exp_q = '{8'hA3};
    check_rx("a3", exp_q);

    // Reset in the middle of the 0x11 frame.
    b1.tx_enable = 1'b1;
    step();
    repeat (70) step();
    check("prerst_line", b1.tx_out, exp_line(8'h11, OS, 70));
    check("prerst_busy", b1.tx_busy, 1);
    #1 reset = 1'b1;
    #1;
    check("midrst_line", b1.tx_out, 1);
    check("midrst_busy", b1.tx_busy, 0);
    check("midrst_count", b1.fifo_count, 0);
    check("midrst_ready", b1.tx_ready, 1);
    #1 reset = 1'b0;
    n_low  = 0;
    n_busy = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (b1.tx_out !== 1'b1) n_low++;
      if (b1.tx_busy !== 1'b0) n_busy++;
    end
    check("postrst_low_cycles", n_low, 0);
    check("postrst_busy_cycles", n_busy, 0);
    check("postrst_count", b1.fifo_count, 0);

    // 8x oversample, two stop bits: two 0x00 frames back to back.
    push2(8'h00);
    push2(8'h00);
    c0 = cyc;
    n = 0;
    while (b2.tx_out === 1'b0 && n < 500) begin
      n++;
      step();
    end
    check("s2_low1", n, 72);
    n = 0;
    while (b2.tx_out === 1'b1 && n < 500) begin
      n++;
      step();
    end
    check("s2_high1", n, 16);
    c1 = cyc;
    check("s2_period", c1 - c0, 88);
    n = 0;
    while (b2.tx_out === 1'b0 && n < 500) begin
      n++;
      step();
    end
    check("s2_low2", n, 72);
    w = 0;
    while (b2.tx_busy === 1'b1 && w < 500) begin
      step();
      w++;
    end
    check("s2_total", cyc - c0, 176);
    check("s2_line_end", b2.tx_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning rxclk cycles per bit (power of two, 4..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-004 SHALL have port rxclk, input, 1, meaning clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port tx_data, input, 8, meaning byte to send; sampled when tx_valid && tx_ready.
REQ-007 SHALL have port tx_valid, input, 1, meaning tx_data is valid.
REQ-008 SHALL have port tx_ready, output, 1, meaning FIFO not full; registered.
REQ-009 SHALL have port tx_enable, input, 1, meaning permit new frames to start.
REQ-010 SHALL have port tx_out, output, 1, meaning serial line, idle high; registered, glitch-free.
REQ-011 SHALL have port tx_busy, output, 1, meaning a frame is in progress (state != IDLE).
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning occupied FIFO entries.

Function
REQ-013 SHALL use frame format 8N1 (or 8N2): start 0, data LSB first, stop 1; each bit exactly OVERSAMPLE cycles.
REQ-014 SHALL push tx_data into the FIFO on an edge where tx_valid && tx_ready; tx_valid with tx_ready low SHALL be ignored (no data loss, no side effect).
REQ-015 SHALL deassert tx_ready on the edge where fifo_count reaches FIFO_DEPTH, and reassert it on the edge after a pop frees an entry (no combinational ready path).
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 IDLE -> START: on an edge where FIFO non-empty and tx_enable=1; pop the head into an 8-bit shift register and drive tx_out=0 from that edge.
REQ-018 START -> DATA after OVERSAMPLE cycles; DATA shifts one bit per OVERSAMPLE cycles via 3-bit bit counter; DATA -> STOP after bit 7.
REQ-019 STOP SHALL hold tx_out=1 for OVERSAMPLE*STOP_BITS cycles; on its last cycle go to START (pop next byte, zero gap) if FIFO non-empty and tx_enable=1, else to IDLE.
REQ-020 Latency: byte pushed at edge k into an empty FIFO while IDLE and enabled SHALL drive tx_out low after edge k+1.
REQ-021 Frame period back-to-back SHALL be (10+STOP_BITS-1)*OVERSAMPLE cycles (160 at defaults).
REQ-022 tx_enable falling mid-frame SHALL NOT truncate the frame; the FSM completes STOP then holds IDLE with FIFO contents retained.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; push into a full FIFO on the same edge as a pop SHALL NOT occur (tx_ready already low).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH nor go below 0.

Reset
REQ-025 On reset assertion, immediately and independent of rxclk: tx_out=1, tx_busy=0, tx_ready=1, fifo_count=0, state IDLE, counters and pointers 0.
REQ-026 Reset mid-frame SHALL abort the frame and discard FIFO contents; tx_out SHALL stay 1 until a new frame starts after reset release.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, START_BIT=0, STOP_BIT=1, DATA_BITS=8 constants, shared with uart_rx.
REQ-028 FIFO SHALL be sub-module uart_tx_fifo (synchronous, registered count/full/empty, same clock and reset).

Verification
REQ-029 Push 0x55 once idle -> tx_out: 0 for 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, then 1; tx_busy high exactly 160 cycles.
REQ-030 Push 0x48,0x69 ("Hi") with bench uart_rx loopback on tx_out -> monitor logs "Hi", no frame error; frames back-to-back, 320 cycles total.
REQ-031 Push 5 bytes with tx_enable=0 -> tx_ready low after 4th push, fifo_count=4, 5th ignored; raise tx_enable -> 4 frames sent in order, tx_ready high on edge after first pop.
REQ-032 Drop tx_enable at cycle 40 of a 0xA3 frame with 2 queued -> 0xA3 completes, line idle, fifo_count=2 retained.
REQ-033 Assert reset at cycle 70 of a frame -> tx_out=1 same time step, fifo_count=0, tx_busy=0; after release with no push, tx_out stays 1 for 200 cycles.
REQ-034 STOP_BITS=2, OVERSAMPLE=8 build, push 0x00 -> low 72 cycles, high 16 cycles, period 88 cycles.
